// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage.
//   Owns the fetch PC and issues word reads over a req/gnt/rvalid memory port.
//   Returned words are buffered with their PC in a small FIFO and handed to
//   decode over valid/ready. A redirect flushes the FIFO and marks in-flight
//   reads for discard.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   imem_req_o / imem_addr_o      fetch request and word address
//   imem_gnt_i                    request accepted
//   imem_rvalid_i / imem_rdata_i  in-order read response
//   redirect_i / redirect_pc_i    restart fetch at a new PC
//   instr_valid_o / instr_ready_i decode handshake
//   instruction_o / pc_o          head instruction and its address
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
//   the outputs in the same cycle when the buffer is empty.

package fetch_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

  state_e       state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;        // PC of the next accepted response
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  fetch_entry_t fifo_q [FIFO_DEPTH];

  logic         req;
  logic         gnt_fire;
  logic         fifo_empty;
  logic         pop;
  logic         rsp_accept;
  logic         bypass;
  logic         push;
  logic [31:0]  redirect_pc_aligned;
  fetch_entry_t head;
  logic         unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Credit rule: never have more reads in flight plus buffered than FIFO slots.
  assign req = (state_q == RUN) &&
               (({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_EXT);
  assign gnt_fire = req & imem_gnt_i;
  assign fifo_empty = (count_q == '0);
  assign pop = !fifo_empty & instr_ready_i;
  assign head = fifo_q[rd_ptr_q];
  assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};

  // A response is kept only when nothing is pending discard and no redirect
  // is killing the current stream this cycle.
  assign rsp_accept = imem_rvalid_i & (discard_q == '0) & !redirect_i;

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty & (discard_q == '0) & imem_rvalid_i &
                  instr_ready_i & !redirect_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_accept & !bypass;

  // Next-state logic for FSM, counters and pointers.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (gnt_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid_i);

    if (rsp_accept) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
    end

    if (imem_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end

    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    // Redirect wins: everything still in flight after this cycle is stale.
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      discard_d  = outstanding_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Instruction buffer storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= '{pc: rsp_pc_q, instr: imem_rdata_i};
    end
  end

  // Output view: head of buffer, NOP/0 when empty.
  always_comb begin
    imem_req_o    = req;
    imem_addr_o   = fetch_pc_q;
    instr_valid_o = !fifo_empty;
    instruction_o = fifo_empty ? NOP_INSTR : head.instr;
    pc_o          = fifo_empty ? 32'h0 : head.pc;
    if (bypass) begin
      instr_valid_o = 1'b1;
      instruction_o = imem_rdata_i;
      pc_o          = rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a cycle table for the startup/stall sequence,
// directed redirect/wrap/reset sequences and a randomized run, all checked
// against a program-order model (expected next PC, memory word = f(address)).
module tb_fetch_stage;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instruction_o (instruction_o),
    .pc_o          (pc_o)
  );

  int checks = 0;
  int errors = 0;
  int deliveries = 0;
  logic [31:0] pend[$];          // addresses granted, awaiting response
  logic [31:0] exp_pc;           // next PC decode should see
  bit          prev_hold;
  logic [31:0] prev_pc, prev_instr;

  typedef struct {
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input bit rdy, input bit rq, input logic [31:0] ad,
                              input bit vl, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.e_req = rq; v.e_addr = ad; v.e_valid = vl; v.e_pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_pc = RPC;
    prev_hold = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req_o), 32'd0);
    check({tag, "_addr"},  imem_addr_o, RPC);
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    check({tag, "_instr"}, instruction_o, NOP);
    check({tag, "_pc"},    pc_o, 32'h0);
  endtask

  // Release reset between edges so the next sampled cycle is the BOOT cycle.
  task automatic do_reset();
    rst_ni = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  // One clock cycle: drive inputs at negedge, sample/check, record grants.
  // rmode: 0 no redirect, 1 redirect, 2 redirect only if gnt and rvalid coincide.
  task automatic step(input bit g, input bit rv_en, input bit rdy, input int rmode,
                      input logic [31:0] rpc, output logic s_req,
                      output logic [31:0] s_addr, output logic s_valid,
                      output logic [31:0] s_pc, output bit hit);
    @(negedge clk_i);
    s_req  = imem_req_o;
    s_addr = imem_addr_o;
    imem_gnt_i = g & imem_req_o;
    if (rv_en && pend.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    hit = (rmode == 1) || (rmode == 2 && imem_gnt_i && imem_rvalid_i);
    redirect_i    = hit;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    #1;
    s_valid = instr_valid_o;
    s_pc    = pc_o;
    if (prev_hold) begin
      check("hold_valid", 32'(instr_valid_o), 32'd1);
      check("hold_pc", pc_o, prev_pc);
      check("hold_instr", instruction_o, prev_instr);
    end
    if (instr_valid_o) begin
      check("deliver_pc", pc_o, exp_pc);
      check("deliver_instr", instruction_o, mem_word(exp_pc));
      if (instr_ready_i) begin
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
    end else begin
      check("idle_instr", instruction_o, NOP);
      check("idle_pc", pc_o, 32'h0);
    end
    if (imem_req_o) check("addr_align", 32'(imem_addr_o[1:0]), 32'd0);
    if (hit) exp_pc = {rpc[31:2], 2'b00};
    prev_hold  = instr_valid_o && !instr_ready_i && !hit;
    prev_pc    = pc_o;
    prev_instr = instruction_o;
    if (imem_gnt_i) pend.push_back(imem_addr_o);
    check("outstanding_bound", 32'(pend.size() <= DEPTH), 32'd1);
  endtask

  vec_t tbl[17];

  initial begin
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc;
    bit          hit, found, wrap_seen;

    // Cycle 0 is BOOT; gnt always, responses one cycle after grant.
    tbl[0]  = mk(1, 0, 32'h00, 0, 32'h00);
    tbl[1]  = mk(1, 1, 32'h00, 0, 32'h00);
    tbl[2]  = mk(1, 1, 32'h04, 0, 32'h00);
    tbl[3]  = mk(1, 0, 32'h08, 1, 32'h00);
    tbl[4]  = mk(1, 1, 32'h08, 1, 32'h04);
    tbl[5]  = mk(1, 1, 32'h0C, 0, 32'h00);
    tbl[6]  = mk(1, 0, 32'h10, 1, 32'h08);
    tbl[7]  = mk(1, 1, 32'h10, 1, 32'h0C);
    tbl[8]  = mk(0, 1, 32'h14, 0, 32'h00);
    tbl[9]  = mk(0, 0, 32'h18, 1, 32'h10);
    tbl[10] = mk(0, 0, 32'h18, 1, 32'h10);
    tbl[11] = mk(0, 0, 32'h18, 1, 32'h10);
    tbl[12] = mk(1, 0, 32'h18, 1, 32'h10);
    tbl[13] = mk(1, 1, 32'h18, 1, 32'h14);
    tbl[14] = mk(1, 1, 32'h1C, 0, 32'h00);
    tbl[15] = mk(1, 0, 32'h20, 1, 32'h18);
    tbl[16] = mk(1, 1, 32'h20, 1, 32'h1C);

    model_reset();
    #3;
    check_reset_outputs("por");
    do_reset();

    foreach (tbl[i]) begin
      step(1, 1, tbl[i].rdy, 0, 32'h0, s_req, s_addr, s_valid, s_pc, hit);
      check($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
      check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
    end

    // Two reads in flight, then redirect to an unaligned target.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 0, 1, 0, 32'h0, s_req, s_addr, s_valid, s_pc, hit);
      found = (pend.size() == 2);
    end
    check("two_outstanding", 32'(found), 32'd1);
    step(0, 0, 1, 1, 32'h0000_0103, s_req, s_addr, s_valid, s_pc, hit);
    step(1, 1, 1, 0, 32'h0, s_req, s_addr, s_valid, s_pc, hit);
    check("flush_valid", 32'(s_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 1, 0, 32'h0, s_req, s_addr, s_valid, s_pc, hit);
      if (s_valid && !found) begin
        found = 1'b1;
        check("redirect_first_pc", s_pc, 32'h0000_0100);
      end
    end
    check("redirect_delivered", 32'(found), 32'd1);

    // Redirect coinciding with a grant and a response.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1, 1, 1, 2, 32'h0000_0200, s_req, s_addr, s_valid, s_pc, hit);
      found = hit;
    end
    check("gnt_rvalid_redirect_hit", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 1, 0, 32'h0, s_req, s_addr, s_valid, s_pc, hit);
      if (s_valid && !found) begin
        found = 1'b1;
        check("coincide_first_pc", s_pc, 32'h0000_0200);
      end
    end
    check("coincide_delivered", 32'(found), 32'd1);

    // Address wrap at the top of the address space.
    step(1, 1, 1, 1, 32'hFFFF_FFFF, s_req, s_addr, s_valid, s_pc, hit);
    wrap_seen = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 1, 1, 0, 32'h0, s_req, s_addr, s_valid, s_pc, hit);
      if (wrap_seen) begin
        check("wrap_addr", s_addr, 32'h0000_0000);
        found = 1'b1;
      end
      if (s_req && s_addr == 32'hFFFF_FFFC) wrap_seen = 1'b1;
    end
    check("wrap_reached", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++)
      step(1, 1, 1, 0, 32'h0, s_req, s_addr, s_valid, s_pc, hit);

    // Reset in the middle of a burst.
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, 0, 32'h0, s_req, s_addr, s_valid, s_pc, hit);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("midrst");
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      step(1, 1, 1, 0, 32'h0, s_req, s_addr, s_valid, s_pc, hit);
      if (s_req) begin
        found = 1'b1;
        check("refetch_addr", s_addr, RPC);
      end
    end
    check("refetch_seen", 32'(found), 32'd1);

    // Randomized traffic against the program-order model.
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 10) < 7,
           (($urandom % 40) == 0) ? 1 : 0, $urandom,
           s_req, s_addr, s_valid, s_pc, hit);
    end
    check("random_progress", 32'(deliveries > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
